sram_sp_arbiter: RTL
====================

SRAM_SP_ARBITER -- requirements
Module: sram_sp_arbiter

Interface
REQ-001 Parameter WORD_AW, default 10, SHALL be the word address width.
REQ-002 Parameter DW, default 32, SHALL be the data width, restricted to 8, 16 or 32.
REQ-003 Localparam SW SHALL equal DW/8 and set the byte-select width.
REQ-004 Parameter NUM_WORDS, default 1024, SHALL be the memory depth in words, with NUM_WORDS <= 2**WORD_AW.
REQ-005 Parameter CLEAR_ON_RESET, default 0, SHALL enable zero-fill of the memory after reset when set to 1.
REQ-006 One clock and an asynchronous, active-high reset SHALL be used:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high

REQ-007 For each requester N in {0,1}, the ports SHALL be:
- reqN_valid  in  1  request present
- reqN_ready  out  1  request accepted this cycle
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  WORD_AW  word address
- reqN_wdata  in  DW  write data
- reqN_sel  in  SW  byte enables
- rspN_valid  out  1  response strobe
- rspN_rdata  out  DW  read data

REQ-008 The SRAM-side and status ports SHALL be:
- sram_ce  out  1  SRAM chip enable
- sram_we  out  1  SRAM write enable
- sram_oe  out  1  SRAM output enable
- sram_waddr  out  WORD_AW  SRAM word address
- sram_din  out  DW  SRAM write data
- sram_sel  out  SW  SRAM byte selects
- sram_dout  in  DW  SRAM read data, registered inside the SRAM with 1-cycle latency
- init_done  out  1  high when requests are being served

Function
REQ-009 The FSM SHALL have exactly two states, INIT and SERVE.
REQ-010 On reset release, the FSM SHALL enter INIT if CLEAR_ON_RESET=1 and SERVE otherwise.
REQ-011 In INIT, on each cycle the block SHALL drive:
- sram_ce=1, sram_we=1, sram_oe=0
- sram_din=0, sram_sel=all ones
- sram_waddr = clear counter value
REQ-012 The clear counter SHALL start at 0 and increment by 1 per cycle; after the cycle with address NUM_WORDS-1, the FSM SHALL move to SERVE with no wrap and no repeat.
REQ-013 In INIT, reqN_ready SHALL be 0 and init_done SHALL be 0.
REQ-014 In SERVE, init_done SHALL be 1 (registered).
REQ-015 In SERVE, grant SHALL be combinational:
- only one valid requester: that requester is granted
- both valid: the requester selected by the round-robin pointer is granted
- reqN_ready = grantN
REQ-016 The round-robin pointer SHALL reset to prefer port 0 and, after each handshake on port N, SHALL prefer port 1-N; with no handshake it SHALL hold.
REQ-017 On a handshake (reqN_valid & reqN_ready), the SRAM outputs in the same cycle SHALL be:
- sram_ce=1
- sram_we=reqN_we, sram_oe=~reqN_we
- sram_waddr=reqN_addr, sram_din=reqN_wdata, sram_sel=reqN_sel
REQ-018 With no handshake in SERVE, sram_ce, sram_we and sram_oe SHALL be 0 and sram_waddr, sram_din and sram_sel SHALL be 0.
REQ-019 Throughput SHALL be one access per cycle with no bubble between consecutive grants.
REQ-020 rspN_valid SHALL pulse for exactly 1 cycle, exactly 1 cycle after each handshake on port N, for both reads and writes.
REQ-021 rspN_rdata SHALL equal sram_dout in the response cycle for reads and SHALL be 0 otherwise, including write responses and idle cycles.
REQ-022 Requesters SHALL hold reqN_* stable while reqN_valid=1 and reqN_ready=0, and SHALL always accept responses (no response backpressure).
REQ-023 At most one rspN_valid SHALL be high in any cycle.
REQ-024 When a read response and a new grant coincide, both SHALL occur in the same cycle without stall.

Reset
REQ-025 While rst=1, all outputs SHALL be 0, the state SHALL be INIT or SERVE per CLEAR_ON_RESET, the clear counter SHALL be 0, the pointer SHALL prefer port 0, and the pending-response flags SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard any pending response (no rspN_valid after release) and SHALL restart the clear sequence from address 0.

Verification
REQ-027 The bench SHALL cover: CLEAR_ON_RESET=1, NUM_WORDS=16, release rst -> 16 cycles with sram_we=1 at addresses 0..15 and din=0, then init_done=1; reqN_ready=0 throughout.
REQ-028 The bench SHALL cover: both ports continuously reading (port 0 at addr 5 = 0x11111111, port 1 at addr 9 = 0x22222222) -> grants 0,1,0,1; rsp0_rdata=0x11111111 and rsp1_rdata=0x22222222, each 1 cycle after its grant.
REQ-029 The bench SHALL cover: port 0 write to addr 3 of 0xDEADBEEF with sel=4'b0101 into a cleared memory, then a read of addr 3 -> rsp0_rdata=0x00AD00EF; the write response has rdata=0.
REQ-030 The bench SHALL cover: port 1 alone issuing 4 back-to-back reads -> req1_ready=1 for 4 consecutive cycles and rsp1_valid=1 for the following 4 consecutive cycles.
REQ-031 The bench SHALL cover: rst asserted in the cycle after a port 0 read handshake -> rsp0_valid=0 immediately, no response after release, and the clear sequence restarts at address 0.

Source files
------------

// File: rtl/sram_sp_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM,
// with an optional zero-fill pass after reset.
module sram_sp_arbiter #(
  parameter int unsigned WORD_AW        = 10,
  parameter int unsigned DW             = 32,
  parameter int unsigned NUM_WORDS      = 1024,
  parameter int unsigned CLEAR_ON_RESET = 0,
  localparam int unsigned SW            = DW / 8
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic [WORD_AW-1:0] req0_addr,
  input  logic [DW-1:0]      req0_wdata,
  input  logic [SW-1:0]      req0_sel,
  output logic               rsp0_valid,
  output logic [DW-1:0]      rsp0_rdata,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_we,
  input  logic [WORD_AW-1:0] req1_addr,
  input  logic [DW-1:0]      req1_wdata,
  input  logic [SW-1:0]      req1_sel,
  output logic               rsp1_valid,
  output logic [DW-1:0]      rsp1_rdata,

  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [DW-1:0]      sram_din,
  output logic [SW-1:0]      sram_sel,
  input  logic [DW-1:0]      sram_dout,
  output logic               init_done
);

  typedef enum logic {INIT, SERVE} state_t;

  localparam state_t             RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : SERVE;
  localparam logic [WORD_AW-1:0] LAST_ADDR = WORD_AW'(NUM_WORDS - 1);

  state_t             state, state_next;
  logic [WORD_AW-1:0] clr_cnt;
  logic               rr_ptr;
  logic               gnt0, gnt1;
  logic               rd0_q, rd1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_next;
  end

  // Next state, grant and SRAM command; rst gates the clear writes so the
  // SRAM sees nothing while reset is held.
  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_oe    = 1'b0;
    sram_waddr = '0;
    sram_din   = '0;
    sram_sel   = '0;
    case (state)
      INIT: begin
        if (!rst) begin
          sram_ce    = 1'b1;
          sram_we    = 1'b1;
          sram_waddr = clr_cnt;
          sram_sel   = '1;
        end
        if (clr_cnt == LAST_ADDR) state_next = SERVE;
      end
      SERVE: begin
        if (init_done) begin
          gnt0 = req0_valid & (~req1_valid | ~rr_ptr);
          gnt1 = req1_valid & (~req0_valid |  rr_ptr);
        end
        if (gnt0) begin
          sram_ce    = 1'b1;
          sram_we    = req0_we;
          sram_oe    = ~req0_we;
          sram_waddr = req0_addr;
          sram_din   = req0_wdata;
          sram_sel   = req0_sel;
        end else if (gnt1) begin
          sram_ce    = 1'b1;
          sram_we    = req1_we;
          sram_oe    = ~req1_we;
          sram_waddr = req1_addr;
          sram_din   = req1_wdata;
          sram_sel   = req1_sel;
        end
      end
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Clear counter, round-robin pointer and one-cycle response tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt    <= '0;
      rr_ptr     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rd0_q      <= 1'b0;
      rd1_q      <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      if (state == INIT && state_next == INIT) clr_cnt <= clr_cnt + 1'b1;
      if (gnt0)      rr_ptr <= 1'b1;
      else if (gnt1) rr_ptr <= 1'b0;
      rsp0_valid <= gnt0;
      rsp1_valid <= gnt1;
      rd0_q      <= gnt0 & ~req0_we;
      rd1_q      <= gnt1 & ~req1_we;
      init_done  <= (state_next == SERVE);
    end
  end

  // The SRAM registers its read data, so it lines up with the response cycle.
  assign rsp0_rdata = rd0_q ? sram_dout : '0;
  assign rsp1_rdata = rd1_q ? sram_dout : '0;

endmodule
